// File: rtl/bcluster_stream_pe.sv
// Streaming sparse power-of-two dot-product engine: NUM_TG*LANES channels over K activations
// per beat, double-buffered weights, accumulating across a runtime number of beats.
module bcluster_stream_pe #(
    parameter int unsigned NUM_TG  = 2,
    parameter int unsigned LANES   = 4,
    parameter int unsigned K       = 4,
    parameter int unsigned ACT_W   = 16,
    parameter int unsigned PSUM_W  = 16,
    parameter int unsigned SHIFT_W = 3,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned STEP_W  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  w_valid,
    output logic                                  w_ready,
    input  logic [NUM_TG*LANES*K-1:0]             w_mask,
    input  logic [NUM_TG*LANES*K-1:0]             w_sign,
    input  logic [NUM_TG*LANES*K*SHIFT_W-1:0]     w_shift,
    input  logic                                  start_valid,
    output logic                                  start_ready,
    input  logic [STEP_W-1:0]                     num_steps,
    input  logic [NUM_TG*LANES*PSUM_W-1:0]        psum_in,
    input  logic                                  act_valid,
    output logic                                  act_ready,
    input  logic [K*ACT_W-1:0]                    act_in,
    output logic                                  result_valid,
    input  logic                                  result_ready,
    output logic [NUM_TG*LANES*PSUM_W-1:0]        result_out,
    output logic [NUM_TG*LANES-1:0]               sat_flag
);
    localparam int unsigned C  = NUM_TG * LANES;
    localparam int unsigned CK = C * K;

    localparam logic signed [ACC_W-1:0] PMAX =
        {{(ACC_W - PSUM_W + 1){1'b0}}, {(PSUM_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] PMIN = ~PMAX;

    typedef enum logic [1:0] {StIdle, StRun, StOut} state_e;

    state_e                   state;
    logic [CK-1:0]            cur_mask, cur_sign, shd_mask, shd_sign;
    logic [CK*SHIFT_W-1:0]    cur_shift, shd_shift;
    logic                     shadow_full;
    logic [STEP_W-1:0]        step, steps_lat;
    logic signed [ACC_W-1:0]  acc      [C];
    logic signed [ACC_W-1:0]  acc_d    [C];
    logic signed [ACC_W-1:0]  beat_sum [C];
    logic [C*PSUM_W-1:0]      res_d;
    logic [C-1:0]             sat_d;

    logic w_fire, start_fire, beat_fire, last_beat, enter_out;

    assign w_ready      = !shadow_full;
    assign start_ready  = (state == StIdle);
    assign act_ready    = (state == StRun);
    assign result_valid = (state == StOut);

    assign w_fire     = w_valid && !shadow_full;
    assign start_fire = start_valid && (state == StIdle);
    assign beat_fire  = act_valid && (state == StRun);
    assign last_beat  = (step == steps_lat - 1'b1);
    assign enter_out  = (start_fire && (num_steps == '0)) || (beat_fire && last_beat);

    // Per-channel sum of signed, shifted activations for the active bank.
    always_comb begin
        for (int c = 0; c < C; c++) begin
            beat_sum[c] = '0;
            for (int k = 0; k < K; k++) begin
                logic signed [ACC_W-1:0] mag;
                mag = ACC_W'($signed(act_in[k*ACT_W +: ACT_W]))
                      <<< cur_shift[(c*K+k)*SHIFT_W +: SHIFT_W];
                if (cur_mask[c*K+k]) begin
                    beat_sum[c] = cur_sign[c*K+k] ? beat_sum[c] - mag : beat_sum[c] + mag;
                end
            end
        end
    end

    // Next accumulator value; results are clamped from this so OUT entry sees the final sum.
    always_comb begin
        res_d = '0;
        sat_d = '0;
        for (int c = 0; c < C; c++) begin
            acc_d[c] = acc[c];
            if (start_fire) begin
                acc_d[c] = ACC_W'($signed(psum_in[c*PSUM_W +: PSUM_W]));
            end else if (beat_fire) begin
                acc_d[c] = acc[c] + beat_sum[c];
            end
            if (acc_d[c] > PMAX) begin
                res_d[c*PSUM_W +: PSUM_W] = PMAX[PSUM_W-1:0];
                sat_d[c]                  = 1'b1;
            end else if (acc_d[c] < PMIN) begin
                res_d[c*PSUM_W +: PSUM_W] = PMIN[PSUM_W-1:0];
                sat_d[c]                  = 1'b1;
            end else begin
                res_d[c*PSUM_W +: PSUM_W] = acc_d[c][PSUM_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            cur_mask    <= '0;
            cur_sign    <= '0;
            cur_shift   <= '0;
            shd_mask    <= '0;
            shd_sign    <= '0;
            shd_shift   <= '0;
            shadow_full <= 1'b0;
            step        <= '0;
            steps_lat   <= '0;
            result_out  <= '0;
            sat_flag    <= '0;
            for (int c = 0; c < C; c++) acc[c] <= '0;
        end else begin
            // Swap reads the old shadow; a same-cycle load refills it.
            if (start_fire && shadow_full) begin
                cur_mask  <= shd_mask;
                cur_sign  <= shd_sign;
                cur_shift <= shd_shift;
            end
            if (w_fire) begin
                shd_mask    <= w_mask;
                shd_sign    <= w_sign;
                shd_shift   <= w_shift;
                shadow_full <= 1'b1;
            end else if (start_fire && shadow_full) begin
                shadow_full <= 1'b0;
            end

            for (int c = 0; c < C; c++) acc[c] <= acc_d[c];

            if (enter_out) begin
                result_out <= res_d;
                sat_flag   <= sat_d;
            end

            unique case (state)
                StIdle: begin
                    if (start_valid) begin
                        steps_lat <= num_steps;
                        step      <= '0;
                        state     <= (num_steps == '0) ? StOut : StRun;
                    end
                end
                StRun: begin
                    if (act_valid) begin
                        step <= step + 1'b1;
                        if (last_beat) state <= StOut;
                    end
                end
                StOut: begin
                    if (result_ready) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bcluster_stream_pe.sv
// Directed self-checking bench for bcluster_stream_pe with hand-computed expected results.
module tb_bcluster_stream_pe;
    localparam int C       = 8;
    localparam int K       = 4;
    localparam int ACT_W   = 16;
    localparam int PSUM_W  = 16;
    localparam int SHIFT_W = 3;
    localparam int STEP_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    w_valid, w_ready;
    logic [C*K-1:0]          w_mask, w_sign;
    logic [C*K*SHIFT_W-1:0]  w_shift;
    logic                    start_valid, start_ready;
    logic [STEP_W-1:0]       num_steps;
    logic [C*PSUM_W-1:0]     psum_in;
    logic                    act_valid, act_ready;
    logic [K*ACT_W-1:0]      act_in;
    logic                    result_valid, result_ready;
    logic [C*PSUM_W-1:0]     result_out;
    logic [C-1:0]            sat_flag;

    int n_checks = 0;
    int n_fail   = 0;
    bit watch_act = 0;
    bit act_seen  = 0;

    bcluster_stream_pe dut (
        .clk          (clk),
        .rst          (rst),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_mask       (w_mask),
        .w_sign       (w_sign),
        .w_shift      (w_shift),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .num_steps    (num_steps),
        .psum_in      (psum_in),
        .act_valid    (act_valid),
        .act_ready    (act_ready),
        .act_in       (act_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_out   (result_out),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (watch_act && act_ready) act_seen = 1'b1;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_w();
        w_mask  = '0;
        w_sign  = '0;
        w_shift = '0;
    endtask

    task automatic set_tap(input int c, input int k, input bit s, input int sh);
        w_mask[c*K+k] = 1'b1;
        w_sign[c*K+k] = s;
        w_shift[(c*K+k)*SHIFT_W +: SHIFT_W] = SHIFT_W'(sh);
    endtask

    task automatic set_psum(input int c, input int v);
        psum_in[c*PSUM_W +: PSUM_W] = PSUM_W'(v);
    endtask

    function automatic logic [K*ACT_W-1:0] acts(input int a0, input int a1, input int a2,
                                                input int a3);
        return {ACT_W'(a3), ACT_W'(a2), ACT_W'(a1), ACT_W'(a0)};
    endfunction

    function automatic logic signed [63:0] res(input int c);
        logic signed [PSUM_W-1:0] v;
        v = result_out[c*PSUM_W +: PSUM_W];
        return 64'(v);
    endfunction

    task automatic load_w();
        int n = 0;
        w_valid = 1'b1;
        while (!w_ready && n < 20) begin tick(); n++; end
        check_eq("load_w_ready", w_ready, 1);
        tick();
        w_valid = 1'b0;
    endtask

    task automatic start_job(input int steps);
        int n = 0;
        start_valid = 1'b1;
        num_steps   = STEP_W'(steps);
        while (!start_ready && n < 20) begin tick(); n++; end
        check_eq("start_ready_wait", start_ready, 1);
        tick();
        start_valid = 1'b0;
    endtask

    task automatic beat(input logic [K*ACT_W-1:0] a);
        int n = 0;
        act_valid = 1'b1;
        act_in    = a;
        while (!act_ready && n < 20) begin tick(); n++; end
        check_eq("act_ready_wait", act_ready, 1);
        tick();
        act_valid = 1'b0;
    endtask

    task automatic collect();
        int n = 0;
        while (!result_valid && n < 20) begin tick(); n++; end
        check_eq("result_valid_wait", result_valid, 1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; w_valid = 0; start_valid = 0; act_valid = 0; result_ready = 0;
        num_steps = '0; psum_in = '0; act_in = '0;
        clear_w();
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_w_ready", w_ready, 1);
        check_eq("rst_start_ready", start_ready, 1);
        check_eq("rst_act_ready", act_ready, 0);
        check_eq("rst_result_valid", result_valid, 0);

        // Basic accumulate: ch0 weights all +1, two beats of {1,2,3,4}.
        clear_w();
        for (int k = 0; k < K; k++) set_tap(0, k, 0, 0);
        load_w();
        for (int c = 0; c < C; c++) set_psum(c, c * 10 + 1);
        set_psum(0, 5);
        start_job(2);
        beat(acts(1, 2, 3, 4));
        check_eq("basic_rv_early", result_valid, 0);
        beat(acts(1, 2, 3, 4));
        check_eq("basic_rv", result_valid, 1);
        check_eq("basic_res0", res(0), 25);
        check_eq("basic_sat0", sat_flag[0], 0);
        for (int c = 1; c < C; c++) check_eq("basic_passthru", res(c), c * 10 + 1);
        collect();

        // Sign, shift and sparsity on ch1 tap2.
        clear_w();
        set_tap(1, 2, 1, 2);
        load_w();
        psum_in = '0;
        start_job(1);
        beat(acts(100, 100, 3, 100));
        check_eq("sign_neg", res(1), -12);
        collect();
        start_job(1);
        beat(acts(100, 100, -3, 100));
        check_eq("sign_pos", res(1), 12);
        collect();

        // Positive saturation with backpressure.
        clear_w();
        set_tap(0, 0, 0, 7);
        load_w();
        psum_in = '0;
        set_psum(0, 32000);
        start_job(1);
        beat(acts(100, 0, 0, 0));
        check_eq("satp_res0", res(0), 32767);
        check_eq("satp_flag0", sat_flag[0], 1);
        check_eq("satp_flag_others", sat_flag[C-1:1], 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_rv", result_valid, 1);
            check_eq("hold_res0", res(0), 32767);
            check_eq("hold_flag0", sat_flag[0], 1);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_eq("release_rv", result_valid, 0);
        check_eq("release_idle", start_ready, 1);

        // Negative saturation.
        clear_w();
        set_tap(0, 0, 1, 7);
        load_w();
        set_psum(0, -32000);
        start_job(1);
        beat(acts(100, 0, 0, 0));
        check_eq("satn_res0", res(0), -32768);
        check_eq("satn_flag0", sat_flag[0], 1);
        collect();

        // Zero-step job passes psums straight through.
        for (int c = 0; c < C; c++) set_psum(c, c * 100);
        act_seen  = 0;
        watch_act = 1;
        start_job(0);
        check_eq("zero_rv", result_valid, 1);
        for (int c = 0; c < C; c++) check_eq("zero_res", res(c), c * 100);
        check_eq("zero_sat", sat_flag, 0);
        collect();
        tick();
        watch_act = 0;
        check_eq("zero_no_act_ready", act_seen, 0);

        // Double buffer: A=+1, B=+2, C=+4 on ch0 tap0.
        psum_in = '0;
        clear_w(); set_tap(0, 0, 0, 0);
        load_w();
        start_job(2);
        clear_w(); set_tap(0, 0, 0, 1);
        load_w();
        check_eq("db_shadow_full", w_ready, 0);
        clear_w(); set_tap(0, 0, 0, 2);
        w_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("db_refuse_c", w_ready, 0);
        end
        w_valid = 1'b0;
        beat(acts(1, 0, 0, 0));
        beat(acts(1, 0, 0, 0));
        check_eq("db_job1_bankA", res(0), 2);
        collect();
        check_eq("db_pre_swap", w_ready, 0);
        start_job(1);
        check_eq("db_w_ready_after_swap", w_ready, 1);
        beat(acts(3, 0, 0, 0));
        check_eq("db_job2_bankB", res(0), 6);
        collect();

        // Start and load in the same cycle: active stays B, C lands in the shadow.
        w_valid = 1'b1; start_valid = 1'b1; num_steps = 8'd1;
        tick();
        w_valid = 1'b0; start_valid = 1'b0;
        check_eq("sim_shadow_full", w_ready, 0);
        check_eq("sim_run", act_ready, 1);
        beat(acts(3, 0, 0, 0));
        check_eq("sim_job3_bankB", res(0), 6);
        collect();
        start_job(1);
        check_eq("sim_swap_w_ready", w_ready, 1);
        beat(acts(3, 0, 0, 0));
        check_eq("sim_job4_bankC", res(0), 12);
        collect();

        // Reset mid-RUN with the shadow full.
        clear_w(); set_tap(0, 0, 0, 3);
        load_w();
        start_job(3);
        clear_w(); set_tap(0, 0, 0, 4);
        load_w();
        beat(acts(3, 0, 0, 0));
        check_eq("mid_run", act_ready, 1);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_eq("mrst_start_ready", start_ready, 1);
        check_eq("mrst_act_ready", act_ready, 0);
        check_eq("mrst_result_valid", result_valid, 0);
        check_eq("mrst_w_ready", w_ready, 1);
        check_eq("mrst_result_zero", result_out == '0, 1);
        check_eq("mrst_sat_zero", sat_flag, 0);
        for (int c = 0; c < C; c++) set_psum(c, 7);
        start_job(1);
        beat(acts(3, 3, 3, 3));
        check_eq("mrst_bank_cleared", res(0), 7);
        collect();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
